mult_pipe_sa: RTL and testbench

Parametrised, fully pipelined shift-and-add multiplier for the FFT datapath (twiddle and windowing products). It has one stage per multiplier bit and accepts one product per cycle. Valid/ready flow control stalls the whole pipe under backpressure, and a synchronous flush drops all in-flight items. Optional two's-complement mode is selected per operand pair.

---
 rtl/mult_pipe_pkg.sv | 22 ++
 rtl/mult_pipe_sa_stage.sv | 91 +++++++++
 rtl/mult_pipe_sa.sv | 100 ++++++++++
 tb/tb_mult_pipe_sa.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pipe_pkg.sv
// Shared widths, width helper and stage record for the shift-and-add multiplier pipe.
package mult_pipe_pkg;

   localparam int MULT_A_W = 16;
   localparam int MULT_B_W = 8;

   function automatic int prod_w(input int a, input int b);
      return a + b;
   endfunction

   localparam int MULT_P_W = prod_w(MULT_A_W, MULT_B_W);

   // One stage's contents at the default widths.
   typedef struct packed {
      logic                vld;
      logic [MULT_P_W-1:0] mcand;
      logic [MULT_B_W-1:0] mplier;
      logic [MULT_P_W-1:0] sum;
      logic                sgn;
   } mult_stage_t;

endpackage

// File: rtl/mult_pipe_sa_stage.sv
// One shift-and-add stage: conditional add (or subtract on the signed MSB stage), hold on stall.
// The subtract path and signed flag exist only when MULT_PIPE_SIGNED_EN is defined.
module mult_pipe_sa_stage
   import mult_pipe_pkg::*;
#(
   parameter int P_W      = MULT_P_W,
   parameter int B_W      = MULT_B_W,
   parameter bit IS_FIRST = 1'b0,
   parameter bit IS_LAST  = 1'b0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           advance,
   input  logic           flush,
   input  logic           in_vld,
   input  logic [P_W-1:0] in_mcand,
   input  logic [B_W-1:0] in_mplier,
   input  logic [P_W-1:0] in_sum,
   input  logic           in_sgn,
   output logic           vld_q,
   output logic [P_W-1:0] mcand_q,
   output logic [B_W-1:0] mplier_q,
   output logic [P_W-1:0] sum_q,
   output logic           sgn_q
);

   logic [P_W-1:0] mcand_k;
   logic [P_W-1:0] sum_nxt;

   // The head stage sees a*2^0 straight from the input; every later stage doubles it.
   assign mcand_k = IS_FIRST ? in_mcand : {in_mcand[P_W-2:0], 1'b0};

`ifdef MULT_PIPE_SIGNED_EN
   always_comb begin
      sum_nxt = in_sum;
      if (in_mplier[0]) begin
         if (IS_LAST && in_sgn)
            sum_nxt = in_sum - mcand_k;
         else
            sum_nxt = in_sum + mcand_k;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sgn_q <= 1'b0;
      else if (flush)
         sgn_q <= 1'b0;
      else if (advance)
         sgn_q <= in_vld ? in_sgn : 1'b0;
   end
`else
   logic unused_sgn;
   assign unused_sgn = in_sgn ^ IS_LAST;
   assign sgn_q      = 1'b0;

   always_comb begin
      sum_nxt = in_sum;
      if (in_mplier[0])
         sum_nxt = in_sum + mcand_k;
   end
`endif

   // Bubbles load all-zero so an empty slot never carries stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q    <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         sum_q    <= '0;
      end else if (flush) begin
         vld_q    <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         sum_q    <= '0;
      end else if (advance) begin
         if (in_vld) begin
            vld_q    <= 1'b1;
            mcand_q  <= mcand_k;
            mplier_q <= in_mplier >> 1;
            sum_q    <= sum_nxt;
         end else begin
            vld_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sum_q    <= '0;
         end
      end
   end

endmodule

// File: rtl/mult_pipe_sa.sv
// Fully pipelined shift-and-add multiplier, one stage per multiplier bit, valid/ready with flush.
// Define MULT_PIPE_SIGNED_EN to honour in_signed (two's-complement operands per item).
module mult_pipe_sa
   import mult_pipe_pkg::*;
#(
   parameter int A_W = MULT_A_W,
   parameter int B_W = MULT_B_W,
   parameter int P_W = prod_w(A_W, B_W)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [A_W-1:0] in_a,
   input  logic [B_W-1:0] in_b,
   input  logic           in_signed,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [P_W-1:0] out_p
);

   logic                    advance;
   logic [B_W-1:0]          vld_q;
   logic [B_W-1:0][P_W-1:0] mcand_q;
   logic [B_W-1:0][B_W-1:0] mplier_q;
   logic [B_W-1:0][P_W-1:0] sum_q;
   logic [B_W-1:0]          sgn_q;
   logic [P_W-1:0]          a_ext;
   logic                    sgn_in;
   logic                    unused_tail;

   assign advance  = out_ready | ~out_valid;
   assign in_ready = advance & ~flush;

`ifdef MULT_PIPE_SIGNED_EN
   logic signed [A_W-1:0] a_s;
   logic signed [P_W-1:0] a_sx;
   assign a_s    = in_a;
   assign a_sx   = P_W'(a_s);
   assign sgn_in = in_signed;
   assign a_ext  = in_signed ? a_sx : P_W'(in_a);
`else
   logic unused_signed;
   assign unused_signed = in_signed;
   assign sgn_in        = 1'b0;
   assign a_ext         = P_W'(in_a);
`endif

   for (genvar k = 0; k < B_W; k++) begin : g_stage
      logic           pv;
      logic [P_W-1:0] pm;
      logic [B_W-1:0] pb;
      logic [P_W-1:0] ps;
      logic           pg;

      if (k == 0) begin : g_head
         assign pv = in_valid;
         assign pm = a_ext;
         assign pb = in_b;
         assign ps = '0;
         assign pg = sgn_in;
      end else begin : g_body
         assign pv = vld_q[k-1];
         assign pm = mcand_q[k-1];
         assign pb = mplier_q[k-1];
         assign ps = sum_q[k-1];
         assign pg = sgn_q[k-1];
      end

      mult_pipe_sa_stage #(
         .P_W      (P_W),
         .B_W      (B_W),
         .IS_FIRST (k == 0),
         .IS_LAST  (k == B_W - 1)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .advance   (advance),
         .flush     (flush),
         .in_vld    (pv),
         .in_mcand  (pm),
         .in_mplier (pb),
         .in_sum    (ps),
         .in_sgn    (pg),
         .vld_q     (vld_q[k]),
         .mcand_q   (mcand_q[k]),
         .mplier_q  (mplier_q[k]),
         .sum_q     (sum_q[k]),
         .sgn_q     (sgn_q[k])
      );
   end

   // The tail stage's multiplicand, leftover multiplier bits and sign flag have no consumer.
   assign unused_tail = ^{mcand_q[B_W-1], mplier_q[B_W-1], sgn_q[B_W-1]};

   assign out_valid = vld_q[B_W-1];
   assign out_p     = sum_q[B_W-1];

endmodule

// File: tb/tb_mult_pipe_sa.sv
// Directed, table-driven bench for mult_pipe_sa at default widths (16x8 -> 24).
module tb_mult_pipe_sa;

   localparam int A_W = 16;
   localparam int B_W = 8;
   localparam int P_W = 24;
`ifdef MULT_PIPE_SIGNED_EN
   localparam bit SEN = 1'b1;
`else
   localparam bit SEN = 1'b0;
`endif

   logic           clk       = 1'b0;
   logic           rst_n     = 1'b0;
   logic           flush     = 1'b0;
   logic           in_valid  = 1'b0;
   logic           in_signed = 1'b0;
   logic           out_ready = 1'b1;
   logic [A_W-1:0] in_a      = '0;
   logic [B_W-1:0] in_b      = '0;
   logic           in_ready;
   logic           out_valid;
   logic [P_W-1:0] out_p;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      string          name;
      logic [A_W-1:0] a;
      logic [B_W-1:0] b;
      logic           s;
      logic [P_W-1:0] p;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   mult_pipe_sa dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_signed (in_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [P_W-1:0] act, input logic [P_W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
   endtask

   // One isolated item: quiet output for 7 edges after acceptance, product on the 8th, quiet again.
   task automatic run_one(input string name, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                          input logic s, input logic [P_W-1:0] exp);
      logic early;
      early     = 1'b0;
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_signed = s;
      step();
      in_valid  = 1'b0;
      in_signed = 1'b0;
      for (int i = 0; i < B_W - 1; i++) begin
         if (out_valid !== 1'b0 || out_p !== '0) early = 1'b1;
         step();
      end
      check({name, "_quiet_before"}, P_W'(early), '0);
      check({name, "_valid"}, P_W'(out_valid), 1);
      check({name, "_p"}, out_p, exp);
      step();
      check({name, "_quiet_after"}, P_W'(out_valid) | out_p, '0);
   endtask

   initial begin
      logic quiet;

      vecs[0] = '{"u_300x200",   16'd300,  8'd200, 1'b0, 24'd60000};
      vecs[1] = '{"u_ffffxff",   16'hFFFF, 8'hFF,  1'b0, 24'hFEFF01};
      vecs[2] = '{"u_1x1",       16'h0001, 8'h01,  1'b0, 24'h000001};
      vecs[3] = '{"u_0x55",      16'h0000, 8'h55,  1'b0, 24'h000000};
      vecs[4] = '{"u_fffdx80",   16'hFFFD, 8'h80,  1'b0, 24'h7FFE80};
      vecs[5] = '{"u_8000x7f",   16'h8000, 8'h7F,  1'b0, 24'h3F8000};
      vecs[6] = '{"s_fffdx80",   16'hFFFD, 8'h80,  1'b1, SEN ? 24'h000180 : 24'h7FFE80};
      vecs[7] = '{"s_8000x7f",   16'h8000, 8'h7F,  1'b1, SEN ? 24'hC08000 : 24'h3F8000};
      vecs[8] = '{"s_ffffxff",   16'hFFFF, 8'hFF,  1'b1, SEN ? 24'h000001 : 24'hFEFF01};
      vecs[9] = '{"s_5xff",      16'h0005, 8'hFF,  1'b1, SEN ? 24'hFFFFFB : 24'h0004FB};

      // Reset state, including acceptance by an empty pipe with no consumer.
      #2;
      check("rst_out_valid", P_W'(out_valid), '0);
      check("rst_out_p", out_p, '0);
      check("rst_in_ready", P_W'(in_ready), 1);
      out_ready = 1'b0;
      #1;
      check("empty_accepts_no_ready", P_W'(in_ready), 1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();

      for (int v = 0; v < NV; v++)
         run_one(vecs[v].name, vecs[v].a, vecs[v].b, vecs[v].s, vecs[v].p);

      // Back-to-back items come out on consecutive cycles.
      in_valid = 1'b1; in_a = 16'hFFFF; in_b = 8'hFF; step();
      in_a = 16'h0001; in_b = 8'h01; step();
      in_a = 16'h0000; in_b = 8'h55; step();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check("b2b_0", out_valid ? out_p : 24'hDEAD00, 24'hFEFF01);
      step();
      check("b2b_1", out_valid ? out_p : 24'hDEAD00, 24'h000001);
      step();
      check("b2b_2", out_valid ? out_p : 24'hDEAD00, 24'h000000);
      step();
      check("b2b_end", P_W'(out_valid), '0);

      // Backpressure: fill with items k -> (k+1)*3, stall three cycles, then drain in order.
      for (int k = 0; k < B_W; k++) begin
         in_valid = 1'b1; in_a = A_W'(k + 1); in_b = 8'd3;
         step();
      end
      in_a = A_W'(9); in_b = 8'd3;
      out_ready = 1'b0;
      #1;
      check("bp_in_ready_low", P_W'(in_ready), '0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_hold", out_valid ? out_p : 24'hDEAD00, 24'd3);
         check("bp_in_ready_hold", P_W'(in_ready), '0);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         check("bp_item", out_valid ? out_p : 24'hDEAD00, P_W'(3 * (c + 1)));
         step();
         if (c == 0) begin in_a = A_W'(10); in_b = 8'd3; end
         if (c == 1) in_valid = 1'b0;
      end
      check("bp_drained", P_W'(out_valid), '0);

      // Flush with five items in flight and a new item offered in the same cycle.
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; in_a = A_W'(k + 20); in_b = 8'd7;
         step();
      end
      in_a = 16'd99; in_b = 8'd2; flush = 1'b1;
      #1;
      check("flush_in_ready", P_W'(in_ready), '0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < B_W; i++) begin
         if (out_valid !== 1'b0 || out_p !== '0) quiet = 1'b0;
         step();
      end
      check("flush_quiet", P_W'(quiet), 1);
      run_one("post_flush", 16'd7, 8'd9, 1'b0, 24'd63);

      // Asynchronous reset with the pipe full.
      for (int k = 0; k < B_W; k++) begin
         in_valid = 1'b1; in_a = A_W'(k + 2); in_b = 8'd5;
         step();
      end
      in_valid = 1'b0;
      check("pre_rst_p", out_valid ? out_p : 24'hDEAD00, 24'd10);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", P_W'(out_valid), '0);
      check("midrst_out_p", out_p, '0);
      check("midrst_in_ready", P_W'(in_ready), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < B_W + 2; i++) begin
         if (out_valid !== 1'b0 || out_p !== '0) quiet = 1'b0;
         step();
      end
      check("post_rst_quiet", P_W'(quiet), 1);
      run_one("post_rst", 16'd11, 8'd13, 1'b0, 24'd143);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
